// File: rtl/eth_rgmii_pkg.sv
// Shared RGMII definitions: speed encodings, divider defaults, mode decode.
package eth_rgmii_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  // 125 MHz clk cycles per TX clock period at 100 and 10 Mb/s
  localparam int CLK_DIV_100_DEF = 5;
  localparam int CLK_DIV_10_DEF  = 50;

  // Count at which the 100 Mb/s clock falls mid-cycle (rising half high, falling half low)
  localparam int FALL_HALF_100 = 2;

  typedef enum logic [1:0] {
    MODE_1000 = 2'd0,
    MODE_100  = 2'd1,
    MODE_10   = 2'd2
  } tx_mode_e;

  // 2'b11 is treated as gigabit
  function automatic tx_mode_e decode_speed(input logic [1:0] spd);
    case (spd)
      SPEED_10:  return MODE_10;
      SPEED_100: return MODE_100;
      default:   return MODE_1000;
    endcase
  endfunction

endpackage

// File: rtl/rgmii_tx_if_if.sv
// MAC-side GMII transmit bus: MAC drives data/control, PHY side returns the sample strobe.
interface rgmii_tx_if_if;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       mac_gmii_tx_clk_en;

  modport master (
    output gmii_txd,
    output gmii_tx_en,
    output gmii_tx_er,
    input  mac_gmii_tx_clk_en
  );

  modport slave (
    input  gmii_txd,
    input  gmii_tx_en,
    input  gmii_tx_er,
    output mac_gmii_tx_clk_en
  );
endinterface

// File: rtl/rgmii_tx_clk_gen.sv
// Speed register, 10/100 divider, forwarded TX clock pattern and MAC sample strobe.
// All outputs are registered from the next-cycle count so they line up with it.
module rgmii_tx_clk_gen
  import eth_rgmii_pkg::*;
#(
  parameter int CLK_DIV_100 = CLK_DIV_100_DEF,
  parameter int CLK_DIV_10  = CLK_DIV_10_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  output logic       clk_en,
  output logic       mii_select,
  output logic       tx_clk_1,
  output logic       tx_clk_2
);

  localparam int CNT_W = $clog2(CLK_DIV_10);
  localparam logic [CNT_W-1:0] TC_100   = CNT_W'(CLK_DIV_100 - 1);
  localparam logic [CNT_W-1:0] TC_10    = CNT_W'(CLK_DIV_10 - 1);
  localparam logic [CNT_W-1:0] FALL_100 = CNT_W'(FALL_HALF_100);
  localparam logic [CNT_W-1:0] HIGH_100 = CNT_W'(CLK_DIV_100 / 2);
  localparam logic [CNT_W-1:0] HIGH_10  = CNT_W'(CLK_DIV_10 / 2);

  logic [1:0]       speed_q, speed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             clk_en_q, clk_en_d;
  logic             mii_q, mii_d;
  logic             clk1_q, clk1_d;
  logic             clk2_q, clk2_d;
  tx_mode_e         mode_d;

  // Next speed/count; a speed change abandons the current period and restarts at 0
  always_comb begin
    speed_d  = speed_q;
    count_d  = '0;
    clk_en_d = 1'b1;
    mii_d    = 1'b0;
    clk1_d   = 1'b1;
    clk2_d   = 1'b0;
    if (speed != speed_q) begin
      speed_d = speed;
    end else begin
      case (decode_speed(speed_q))
        MODE_100: count_d = (count_q == TC_100) ? '0 : count_q + CNT_W'(1);
        MODE_10:  count_d = (count_q == TC_10)  ? '0 : count_q + CNT_W'(1);
        default:  count_d = '0;
      endcase
    end
    mode_d = decode_speed(speed_d);
    case (mode_d)
      MODE_100: begin
        mii_d    = 1'b1;
        clk_en_d = (count_d == TC_100);
        clk1_d   = (count_d <= FALL_100);
        clk2_d   = (count_d < HIGH_100);
      end
      MODE_10: begin
        mii_d    = 1'b1;
        clk_en_d = (count_d == TC_10);
        clk1_d   = (count_d < HIGH_10);
        clk2_d   = (count_d < HIGH_10);
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q  <= SPEED_1000;
      count_q  <= '0;
      clk_en_q <= 1'b0;
      mii_q    <= 1'b0;
      clk1_q   <= 1'b0;
      clk2_q   <= 1'b0;
    end else begin
      speed_q  <= speed_d;
      count_q  <= count_d;
      clk_en_q <= clk_en_d;
      mii_q    <= mii_d;
      clk1_q   <= clk1_d;
      clk2_q   <= clk2_d;
    end
  end

  assign clk_en     = clk_en_q;
  assign mii_select = mii_q;
  assign tx_clk_1   = clk1_q;
  assign tx_clk_2   = clk2_q;

endmodule

// File: rtl/rgmii_tx_if.sv
// RGMII transmit path: captures MAC data on strobe cycles and drives DDR half-word pairs.
module rgmii_tx_if
  import eth_rgmii_pkg::*;
#(
  parameter int CLK_DIV_100 = CLK_DIV_100_DEF,
  parameter int CLK_DIV_10  = CLK_DIV_10_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       speed,
  rgmii_tx_if_if.slave     gmii,
  output logic             mii_select,
  output logic [3:0]       rgmii_txd_1,
  output logic [3:0]       rgmii_txd_2,
  output logic             rgmii_tx_ctl_1,
  output logic             rgmii_tx_ctl_2,
  output logic             rgmii_tx_clk_1,
  output logic             rgmii_tx_clk_2
);

  logic clk_en;

  rgmii_tx_clk_gen #(
    .CLK_DIV_100 (CLK_DIV_100),
    .CLK_DIV_10  (CLK_DIV_10)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .speed      (speed),
    .clk_en     (clk_en),
    .mii_select (mii_select),
    .tx_clk_1   (rgmii_tx_clk_1),
    .tx_clk_2   (rgmii_tx_clk_2)
  );

  assign gmii.mac_gmii_tx_clk_en = clk_en;

  // Load on strobe cycles; in 10/100 the low nibble goes out on both halves and is held
  always_ff @(posedge clk) begin
    if (rst) begin
      rgmii_txd_1    <= '0;
      rgmii_txd_2    <= '0;
      rgmii_tx_ctl_1 <= 1'b0;
      rgmii_tx_ctl_2 <= 1'b0;
    end else if (clk_en) begin
      rgmii_txd_1    <= gmii.gmii_txd[3:0];
      rgmii_txd_2    <= mii_select ? gmii.gmii_txd[3:0] : gmii.gmii_txd[7:4];
      rgmii_tx_ctl_1 <= gmii.gmii_tx_en;
      rgmii_tx_ctl_2 <= gmii.gmii_tx_en ^ gmii.gmii_tx_er;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_if.sv
// Directed bench for rgmii_tx_if: gigabit vector table plus 100/10, speed-switch and reset sequences.
module tb_rgmii_tx_if;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic       mii_select;
  logic [3:0] txd1, txd2;
  logic       ctl1, ctl2, c1, c2;

  int n_chk  = 0;
  int n_fail = 0;

  rgmii_tx_if_if bus ();

  rgmii_tx_if dut (
    .clk            (clk),
    .rst            (rst),
    .speed          (speed),
    .gmii           (bus),
    .mii_select     (mii_select),
    .rgmii_txd_1    (txd1),
    .rgmii_txd_2    (txd2),
    .rgmii_tx_ctl_1 (ctl1),
    .rgmii_tx_ctl_2 (ctl2),
    .rgmii_tx_clk_1 (c1),
    .rgmii_tx_clk_2 (c2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] txd;
    logic       en;
    logic       er;
    logic [3:0] e_txd1;
    logic [3:0] e_txd2;
    logic       e_ctl1;
    logic       e_ctl2;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk_en(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (bus.mac_gmii_tx_clk_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_clk_en", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic [1:0] pat100 [5];
    logic [3:0] nib [2];
    logic       exp_hi;

    vecs[0] = '{8'h5A, 1'b1, 1'b0, 4'hA, 4'h5, 1'b1, 1'b1};
    vecs[1] = '{8'hC3, 1'b1, 1'b0, 4'h3, 4'hC, 1'b1, 1'b1};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{8'h12, 1'b0, 1'b1, 4'h2, 4'h1, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    pat100[0] = 2'b11; pat100[1] = 2'b11; pat100[2] = 2'b10;
    pat100[3] = 2'b00; pat100[4] = 2'b00;
    nib[0] = 4'h7; nib[1] = 4'h9;

    rst = 1'b1;
    speed = 2'b10;
    bus.gmii_txd = 8'h00;
    bus.gmii_tx_en = 1'b0;
    bus.gmii_tx_er = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {txd1, txd2, ctl1, ctl2, c1, c2, bus.mac_gmii_tx_clk_en, mii_select}, 32'd0);

    // Gigabit: table of byte/control vectors, one-cycle latency
    rst = 1'b0;
    step();
    chk("gig_clk_en_idle", {c1, c2, bus.mac_gmii_tx_clk_en, mii_select}, 32'b1010);
    for (int i = 0; i < 5; i++) begin
      bus.gmii_txd   = vecs[i].txd;
      bus.gmii_tx_en = vecs[i].en;
      bus.gmii_tx_er = vecs[i].er;
      step();
      chk($sformatf("gig_vec%0d", i),
          {txd1, txd2, ctl1, ctl2, c1, c2, bus.mac_gmii_tx_clk_en},
          {vecs[i].e_txd1, vecs[i].e_txd2, vecs[i].e_ctl1, vecs[i].e_ctl2, 3'b101});
    end

    // 100 Mb/s: nibbles 7 then 9, five cycles each
    speed = 2'b01;
    bus.gmii_txd = {4'hF, nib[0]};
    bus.gmii_tx_en = 1'b1;
    bus.gmii_tx_er = 1'b0;
    wait_clk_en(20);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 5; c++) begin
        step();
        chk($sformatf("m100_p%0d_c%0d", p, c),
            {txd1, txd2, ctl1, ctl2, c1, c2, bus.mac_gmii_tx_clk_en, mii_select},
            {nib[p], nib[p], 2'b11, pat100[c], (c == 4), 1'b1});
        if (c == 4) bus.gmii_txd = {4'hF, nib[1]};
      end
    end

    // 10 Mb/s: one 50-cycle period, 25 high then 25 low
    speed = 2'b00;
    bus.gmii_txd = 8'hA3;
    bus.gmii_tx_en = 1'b1;
    bus.gmii_tx_er = 1'b1;
    wait_clk_en(120);
    for (int c = 0; c < 50; c++) begin
      step();
      exp_hi = (c < 25);
      chk($sformatf("m10_c%0d", c),
          {txd1, txd2, ctl1, ctl2, c1, c2, bus.mac_gmii_tx_clk_en, mii_select},
          {4'h3, 4'h3, 2'b10, exp_hi, exp_hi, (c == 49), 1'b1});
    end

    // Switch 10 -> 1000 at count 30
    repeat (31) step();
    chk("sw_at_count30", {c1, c2, bus.mac_gmii_tx_clk_en}, 32'b000);
    speed = 2'b10;
    bus.gmii_txd = 8'h96;
    bus.gmii_tx_en = 1'b1;
    bus.gmii_tx_er = 1'b0;
    step();
    chk("sw_first", {txd1, txd2, c1, c2, bus.mac_gmii_tx_clk_en, mii_select}, {4'h3, 4'h3, 4'b1010});
    step();
    chk("sw_second", {txd1, txd2, ctl1, ctl2, c1, c2, bus.mac_gmii_tx_clk_en, mii_select},
        {4'h6, 4'h9, 2'b11, 4'b1010});

    // Reset during a 100 Mb/s frame
    speed = 2'b01;
    bus.gmii_txd = 8'h05;
    wait_clk_en(20);
    step();
    step();
    chk("rst_pre_data", {txd1, txd2, ctl1, ctl2}, {4'h5, 4'h5, 2'b11});
    rst = 1'b1;
    step();
    chk("rst_mid_frame", {txd1, txd2, ctl1, ctl2, c1, c2, bus.mac_gmii_tx_clk_en, mii_select}, 32'd0);
    step();
    rst = 1'b0;
    bus.gmii_txd = 8'h0E;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("rst_rel_k%0d", k), {txd1, bus.mac_gmii_tx_clk_en}, {4'h0, (k == 5)});
      if (k == 1) chk("rst_rel_clk", {c1, c2, mii_select}, 32'b111);
    end
    step();
    chk("rst_rel_data", {txd1, txd2, ctl1, ctl2}, {4'hE, 4'hE, 2'b11});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
